ack_bus_arbiter: RTL

ACK_BUS_ARBITER -- requirements
Module: ack_bus_arbiter

---
 rtl/ack_bus_arbiter_if.sv | 45 ++++
 rtl/ack_bus_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ack_bus_arbiter_if.sv
// ack_bus_arbiter_if -- request/ack bus between four requesters and the arbiter.
//
// Requester side (driven by the requesters):
//   req_valid[3:0]   per-requester ack request (MEM=0, SHA=1, AES=2, CTRL=3)
//   req_dest[7:0]    target ID per requester, bits [2i+1:2i] for requester i
//   err_clr          clears the sticky self-ack error flag
// Arbiter side (driven by the arbiter):
//   req_accept[3:0]  request of requester i captured this cycle
//   ack_bus_owned    ID of the current or most recent bus owner
//   ack_bus_busy     grant active
//   ack_valid        single-cycle ack strobe
//   ack_src/ack_dest source and target ID of the strobed ack
//   ack_hit[3:0]     one-hot decode of ack_dest, qualified by ack_valid
//   pending[3:0]     per-requester pending-slot flags
//   self_ack_err     sticky illegal (self-addressed) request flag
//   ack_count[7:0]   acks delivered, wrapping
interface ack_bus_arbiter_if;
  logic [3:0] req_valid;
  logic [7:0] req_dest;
  logic       err_clr;
  logic [3:0] req_accept;
  logic [1:0] ack_bus_owned;
  logic       ack_bus_busy;
  logic       ack_valid;
  logic [1:0] ack_src;
  logic [1:0] ack_dest;
  logic [3:0] ack_hit;
  logic [3:0] pending;
  logic       self_ack_err;
  logic [7:0] ack_count;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_dest, err_clr,
    output req_accept, ack_bus_owned, ack_bus_busy, ack_valid, ack_src,
           ack_dest, ack_hit, pending, self_ack_err, ack_count
  );

  // The requester / environment side.
  modport master (
    output req_valid, req_dest, err_clr,
    input  req_accept, ack_bus_owned, ack_bus_busy, ack_valid, ack_src,
           ack_dest, ack_hit, pending, self_ack_err, ack_count
  );
endinterface

// File: rtl/ack_bus_arbiter.sv
// ack_bus_arbiter -- round-robin arbiter serialising acks from four requesters
// onto one shared ack bus.
//
// Each requester owns one pending slot holding a 2-bit destination. The FSM
// idles until a slot is pending, grants it round-robin (scan starts after the
// last grant), strobes the ack for exactly one cycle (DRIVE), then inserts
// GUARD_CYCLES dead cycles (GUARD) before arbitrating again.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ack_bus_arbiter_if.slave (request inputs, ack bus and status outputs)
//
// Parameter:
//   GUARD_CYCLES  idle cycles after each ack before the next grant (0..7)
module ack_bus_arbiter #(
  parameter int GUARD_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ack_bus_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // Counter preload: GUARD runs while the counter walks down to zero, so
  // loading N-1 gives exactly N guard cycles.
  localparam logic [2:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 3'(GUARD_CYCLES - 1) : 3'd0;

  logic [1:0]      state_q, state_d;
  logic [3:0]      pending_q, pending_d;
  logic [3:0][1:0] dest_q;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ack_dest_q, ack_dest_d;
  logic [2:0]      guard_q, guard_d;
  logic            err_q, err_d;
  logic [7:0]      count_q, count_d;

  logic [3:0]      accept;
  logic            self_err_set;
  logic [1:0]      winner;
  logic [1:0]      cand;
  logic            found;
  logic            drive;

  // Request capture and self-addressed request detection.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    accept       = '0;
    self_err_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_valid[i]) begin
        if (bus.req_dest[2*i +: 2] == 2'(i)) begin
          self_err_set = 1'b1;
        end else if (!pending_q[i]) begin
          accept[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin pick: first pending slot at or after last_grant+1, with wrap.
  always_comb begin
    winner = last_grant_q + 2'd1;
    cand   = winner;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = last_grant_q + 2'd1 + 2'(k);
      if (!found && pending_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic.
  // NOTE: combinational blocks use blocking '=' so later statements see earlier
  // results; the registers below use non-blocking '<=' so all flops update
  // together from the previous cycle's values.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | accept;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ack_dest_d   = ack_dest_q;
    guard_d      = guard_q;
    count_d      = count_q;
    // A new illegal request outranks a clear arriving in the same cycle.
    err_d        = (err_q & ~bus.err_clr) | self_err_set;

    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          owner_d    = winner;
          ack_dest_d = dest_q[winner];
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The owner's slot is still set, so accept[owner_q] is 0 this cycle and
        // the clear below cannot collide with a fresh capture.
        pending_d[owner_q] = 1'b0;
        last_grant_d       = owner_q;
        count_d            = count_q + 8'd1;
        if (GUARD_CYCLES > 0) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (guard_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      last_grant_q <= 2'd3;   // first scan after reset starts at MEM
      owner_q      <= 2'd0;
      ack_dest_q   <= 2'd0;
      guard_q      <= 3'd0;
      err_q        <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ack_dest_q   <= ack_dest_d;
      guard_q      <= guard_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  // NOTE: destination slots carry no reset; a slot is only read while its
  // pending bit is set, and that bit is cleared by reset and set together
  // with the slot write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) begin
        dest_q[i] <= bus.req_dest[2*i +: 2];
      end
    end
  end

  assign drive = (state_q == ST_DRIVE);

  assign bus.req_accept    = accept;
  assign bus.ack_bus_owned = owner_q;
  assign bus.ack_bus_busy  = drive;
  assign bus.ack_valid     = drive;
  assign bus.ack_src       = owner_q;
  assign bus.ack_dest      = ack_dest_q;
  assign bus.ack_hit       = drive ? (4'b0001 << ack_dest_q) : 4'b0000;
  assign bus.pending       = pending_q;
  assign bus.self_ack_err  = err_q;
  assign bus.ack_count     = count_q;

endmodule
